echo_indication_decoder: RTL and testbench

ECHO_INDICATION_DECODER -- requirements
Module: echo_indication_decoder

---
 rtl/echo_indication_decoder_pkg.sv | 28 ++
 rtl/echo_indication_decoder_fifo.sv | 63 ++++++
 rtl/echo_indication_decoder.sv | 104 ++++++++++
 tb/tb_echo_indication_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_indication_decoder_pkg.sv
// Shared message layout and tag decode for the EchoIndication pipe-to-method decoder.
package echo_indication_decoder_pkg;

  localparam int unsigned TAG_W     = 16;
  localparam int unsigned PAYLOAD_W = 128;
  localparam int unsigned MSG_W     = TAG_W + PAYLOAD_W;

  localparam logic [TAG_W-1:0] TAG_HEARD  = 16'd0;
  localparam logic [TAG_W-1:0] TAG_HEARD2 = 16'd1;
  localparam logic [TAG_W-1:0] TAG_HEARD3 = 16'd2;

  typedef enum logic [1:0] {
    METH_HEARD,
    METH_HEARD2,
    METH_HEARD3,
    METH_UNKNOWN
  } method_e;

  function automatic method_e decode_tag(input logic [TAG_W-1:0] tag);
    case (tag)
      TAG_HEARD:  return METH_HEARD;
      TAG_HEARD2: return METH_HEARD2;
      TAG_HEARD3: return METH_HEARD3;
      default:    return METH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/echo_indication_decoder_fifo.sv
// Message buffer: DEPTH entries, power-of-two pointers, registered full/empty flags.
module echo_msg_fifo
  import echo_indication_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = MSG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // full resets high so the producer sees no room until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/echo_indication_decoder.sv
// Decodes buffered EchoIndication pipe messages into heard/heard2/heard3 method calls.
module echo_indication_decoder
  import echo_indication_decoder_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DROP_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pipe_enq__ENA,
  input  logic [MSG_W-1:0]  pipe_enq_v,
  output logic              pipe_enq__RDY,
  output logic              method_heard__ENA,
  output logic [31:0]       method_heard_v,
  input  logic              method_heard__RDY,
  output logic              method_heard2__ENA,
  output logic [15:0]       method_heard2_a,
  output logic [15:0]       method_heard2_b,
  input  logic              method_heard2__RDY,
  output logic              method_heard3__ENA,
  output logic [15:0]       method_heard3_a,
  output logic [31:0]       method_heard3_b,
  output logic [31:0]       method_heard3_c,
  output logic [15:0]       method_heard3_d,
  input  logic              method_heard3__RDY,
  output logic [DROP_W-1:0] drop_count
);

  logic [MSG_W-1:0]     head;
  logic [TAG_W-1:0]     head_tag;
  logic [PAYLOAD_W-1:0] head_payload;
  logic [31:0]          unused_payload_bits;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head_pop;
  logic                 head_drop;
  method_e              head_method;

  echo_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (pipe_enq__ENA),
    .push_data (pipe_enq_v),
    .pop       (head_pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pipe_enq__RDY       = !fifo_full;
  assign head_tag            = head[MSG_W-1:PAYLOAD_W];
  assign head_payload        = head[PAYLOAD_W-1:0];
  assign head_method         = decode_tag(head_tag);
  assign unused_payload_bits = head_payload[31:0];

  assign method_heard_v  = head_payload[127:96];
  assign method_heard2_a = head_payload[127:112];
  assign method_heard2_b = head_payload[111:96];
  assign method_heard3_a = head_payload[127:112];
  assign method_heard3_b = head_payload[111:80];
  assign method_heard3_c = head_payload[79:48];
  assign method_heard3_d = head_payload[47:32];

  // The empty flag is asynchronously set by reset, so every ENA drops at once.
  always_comb begin
    method_heard__ENA  = 1'b0;
    method_heard2__ENA = 1'b0;
    method_heard3__ENA = 1'b0;
    head_pop           = 1'b0;
    head_drop          = 1'b0;
    if (!fifo_empty) begin
      case (head_method)
        METH_HEARD: begin
          method_heard__ENA = method_heard__RDY;
          head_pop          = method_heard__RDY;
        end
        METH_HEARD2: begin
          method_heard2__ENA = method_heard2__RDY;
          head_pop           = method_heard2__RDY;
        end
        METH_HEARD3: begin
          method_heard3__ENA = method_heard3__RDY;
          head_pop           = method_heard3__RDY;
        end
        default: begin
          head_pop  = 1'b1;
          head_drop = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_count <= '0;
    end else if (head_drop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_echo_indication_decoder.sv
// Bench for echo_indication_decoder: queue-based reference model plus directed scenarios.
module tb_echo_indication_decoder;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DROP_W = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              pipe_enq__ENA = 1'b0;
  logic [143:0]      pipe_enq_v = '0;
  logic              pipe_enq__RDY;
  logic              method_heard__ENA;
  logic [31:0]       method_heard_v;
  logic              method_heard__RDY = 1'b0;
  logic              method_heard2__ENA;
  logic [15:0]       method_heard2_a;
  logic [15:0]       method_heard2_b;
  logic              method_heard2__RDY = 1'b0;
  logic              method_heard3__ENA;
  logic [15:0]       method_heard3_a;
  logic [31:0]       method_heard3_b;
  logic [31:0]       method_heard3_c;
  logic [15:0]       method_heard3_d;
  logic              method_heard3__RDY = 1'b0;
  logic [DROP_W-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  echo_indication_decoder #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .pipe_enq__ENA      (pipe_enq__ENA),
    .pipe_enq_v         (pipe_enq_v),
    .pipe_enq__RDY      (pipe_enq__RDY),
    .method_heard__ENA  (method_heard__ENA),
    .method_heard_v     (method_heard_v),
    .method_heard__RDY  (method_heard__RDY),
    .method_heard2__ENA (method_heard2__ENA),
    .method_heard2_a    (method_heard2_a),
    .method_heard2_b    (method_heard2_b),
    .method_heard2__RDY (method_heard2__RDY),
    .method_heard3__ENA (method_heard3__ENA),
    .method_heard3_a    (method_heard3_a),
    .method_heard3_b    (method_heard3_b),
    .method_heard3_c    (method_heard3_c),
    .method_heard3_d    (method_heard3_d),
    .method_heard3__RDY (method_heard3__RDY),
    .drop_count         (drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of messages, the enq-ready flag and the drop tally.
  logic [143:0]      mq[$];
  logic              m_rdy  = 1'b0;
  logic [DROP_W-1:0] m_drop = '0;

  function automatic logic [2:0] exp_enas();
    if (mq.size() == 0) return 3'b000;
    case (mq[0][143:128])
      16'd0:   return {2'b00, method_heard__RDY};
      16'd1:   return {1'b0, method_heard2__RDY, 1'b0};
      16'd2:   return {method_heard3__RDY, 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic head_unknown();
    return (mq.size() != 0) && (mq[0][143:128] > 16'd2);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_rdy  <= 1'b0;
      m_drop <= '0;
    end else begin
      if (head_unknown()) begin
        m_drop <= (m_drop == '1) ? m_drop : m_drop + 1'b1;
        void'(mq.pop_front());
      end else if (exp_enas() != 3'b000) begin
        void'(mq.pop_front());
      end
      if (pipe_enq__ENA && m_rdy) mq.push_back(pipe_enq_v);
      m_rdy <= (mq.size() < DEPTH);
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      check("rst_enq_rdy", pipe_enq__RDY, 0);
      check("rst_enas", {method_heard3__ENA, method_heard2__ENA, method_heard__ENA}, 0);
      check("rst_drop", drop_count, 0);
    end else begin
      check("enq_rdy", pipe_enq__RDY, m_rdy);
      check("drop_count", drop_count, m_drop);
      check("enas", {method_heard3__ENA, method_heard2__ENA, method_heard__ENA}, exp_enas());
      if (exp_enas() == 3'b001) check("heard_v", method_heard_v, mq[0][127:96]);
      if (exp_enas() == 3'b010) begin
        check("heard2_a", method_heard2_a, mq[0][127:112]);
        check("heard2_b", method_heard2_b, mq[0][111:96]);
      end
      if (exp_enas() == 3'b100) begin
        check("heard3_a", method_heard3_a, mq[0][127:112]);
        check("heard3_b", method_heard3_b, mq[0][111:80]);
        check("heard3_c", method_heard3_c, mq[0][79:48]);
        check("heard3_d", method_heard3_d, mq[0][47:32]);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] tag, input logic [127:0] pl);
    pipe_enq__ENA = 1'b1;
    pipe_enq_v    = {tag, pl};
    cyc();
    pipe_enq__ENA = 1'b0;
  endtask

  task automatic set_rdy(input logic [2:0] r);
    {method_heard3__RDY, method_heard2__RDY, method_heard__RDY} = r;
  endtask

  function automatic logic [2:0] enas();
    return {method_heard3__ENA, method_heard2__ENA, method_heard__ENA};
  endfunction

  logic [15:0] b2b_tags [4] = '{16'd0, 16'd1, 16'd2, 16'd0};
  logic [2:0]  b2b_exp  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    // Reset state
    cyc();
    check("lit_reset_rdy", pipe_enq__RDY, 0);
    check("lit_reset_enas", enas(), 0);
    check("lit_reset_drop", drop_count, 0);
    cyc();
    RST = 1'b0;
    #4 check("lit_rdy_before_edge", pipe_enq__RDY, 0);
    cyc();
    #4 check("lit_rdy_after_edge", pipe_enq__RDY, 1);

    // heard with DEADBEEF, one cycle latency
    cyc();
    set_rdy(3'b111);
    push(16'd0, {32'hDEADBEEF, 96'h0});
    #4 check("lit_heard_ena", enas(), 3'b001);
    check("lit_heard_v", method_heard_v, 32'hDEADBEEF);

    // heard3 held off for five cycles
    cyc();
    set_rdy(3'b000);
    push(16'd2, {16'h1234, 32'h01020304, 32'hA5A5A5A5, 16'hBEEF, 32'hCAFEF00D});
    for (int i = 0; i < 5; i++) begin
      #4 check("lit_heard3_blocked", enas(), 0);
      cyc();
    end
    set_rdy(3'b100);
    #4 check("lit_heard3_ena", enas(), 3'b100);
    check("lit_heard3_a", method_heard3_a, 16'h1234);
    check("lit_heard3_b", method_heard3_b, 32'h01020304);
    check("lit_heard3_c", method_heard3_c, 32'hA5A5A5A5);
    check("lit_heard3_d", method_heard3_d, 16'hBEEF);
    cyc();
    #4 check("lit_heard3_single", enas(), 0);

    // Fill, ignored push while full, then drain in order
    cyc();
    set_rdy(3'b000);
    push(16'd0, {32'h11111111, 96'h0});
    push(16'd1, {16'hAAAA, 16'h5555, 96'h0});
    #4 check("lit_full_rdy", pipe_enq__RDY, 0);
    cyc();
    pipe_enq__ENA = 1'b1;
    pipe_enq_v    = {16'd2, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000};
    cyc();
    pipe_enq__ENA = 1'b0;
    set_rdy(3'b111);
    #4 check("lit_drain0_ena", enas(), 3'b001);
    check("lit_drain0_v", method_heard_v, 32'h11111111);
    check("lit_drain0_rdy", pipe_enq__RDY, 0);
    cyc();
    #4 check("lit_drain1_ena", enas(), 3'b010);
    check("lit_drain1_a", method_heard2_a, 16'hAAAA);
    check("lit_drain1_b", method_heard2_b, 16'h5555);
    check("lit_drain1_rdy", pipe_enq__RDY, 1);
    cyc();
    #4 check("lit_violation_ignored", enas(), 0);

    // Unknown tags dropped, then saturation
    cyc();
    push(16'd7, 128'h1);
    push(16'd0, {32'h0BADF00D, 96'h0});
    push(16'hFFFF, 128'h2);
    cyc();
    #4 check("lit_drop_two", drop_count, 2);
    cyc();
    for (int i = 0; i < 300; i++) push(16'h0100 + 16'(i), 128'(i));
    cyc();
    cyc();
    #4 check("lit_drop_sat", drop_count, 8'hFF);

    // Back-to-back, no bubbles
    cyc();
    set_rdy(3'b111);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        pipe_enq__ENA = 1'b1;
        pipe_enq_v    = {b2b_tags[i], 32'h1000_0000 + 32'(i), 96'h0};
      end else begin
        pipe_enq__ENA = 1'b0;
      end
      if (i > 0) begin
        #4 check("lit_b2b_ena", enas(), b2b_exp[i-1]);
      end
      cyc();
    end
    pipe_enq__ENA = 1'b0;

    // Async reset with two buffered messages
    set_rdy(3'b000);
    push(16'd0, {32'h77777777, 96'h0});
    push(16'd1, {32'h88888888, 96'h0});
    set_rdy(3'b001);
    #2 check("lit_pre_reset_ena", enas(), 3'b001);
    RST = 1'b1;
    #1 check("lit_async_ena", enas(), 0);
    check("lit_async_rdy", pipe_enq__RDY, 0);
    check("lit_async_drop", drop_count, 0);
    cyc();
    cyc();
    RST = 1'b0;
    set_rdy(3'b111);
    for (int i = 0; i < 4; i++) begin
      #4 check("lit_no_stale", enas(), 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
